// File: rtl/izh_mon_pkg.sv
// Shared types for the Izhikevich spike monitor: event record, detector states, defaults.
package izh_mon_pkg;

  localparam int ISI_W_DEF = 16;
  localparam logic signed [7:0] THRESH_DEFAULT = 8'sd19;

  // Event record at the default ISI width, for consumers downstream of the monitor.
  typedef struct packed {
    logic                 first;
    logic [ISI_W_DEF-1:0] isi;
  } mon_evt_t;

  typedef enum logic {
    ST_ARMED   = 1'b0,
    ST_REFRACT = 1'b1
  } det_state_e;

endpackage

// File: rtl/izh_event_fifo.sv
// First-word-fall-through event queue; a push into a full queue is taken only alongside a pop.
// While empty the read port keeps showing the last popped entry.
module izh_event_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic push_i,
  input  T     push_dat_i,
  input  logic pop_i,
  output T     pop_dat_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  T             mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic          do_pop, do_push;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  // The slot behind the read pointer is never overwritten while empty.
  assign pop_dat_o = empty_o ? mem_q[rd_q - AW'(1)] : mem_q[rd_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_dat_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/izh_spike_monitor.sv
// Threshold spike detector with refractory hold-off, ISI event queue and windowed rate.
// Spike/event visible one cycle after the sample; events dropped (sticky overflow) when queue full.
module izh_spike_monitor
  import izh_mon_pkg::*;
#(
  parameter logic signed [7:0] THRESH     = THRESH_DEFAULT,
  parameter int                REFRACT    = 2,
  parameter int                ISI_W      = ISI_W_DEF,
  parameter int                FIFO_DEPTH = 4,
  parameter int                WINDOW_W   = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic signed [7:0]       v_mem_i,
  input  logic                    v_valid_i,
  output logic                    spike_o,
  output logic                    evt_valid_o,
  input  logic                    evt_ready_i,
  output logic [ISI_W-1:0]        evt_isi_o,
  output logic                    evt_first_o,
  output logic [7:0]              rate_o,
  output logic                    rate_valid_o,
  output logic                    overflow_o
);

  localparam int RCNT_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam logic [RCNT_W-1:0] RCNT_LOAD = RCNT_W'(REFRACT);
  localparam logic [ISI_W-1:0]  ISI_MAX   = '1;

  typedef struct packed {
    logic             first;
    logic [ISI_W-1:0] isi;
  } evt_t;

  det_state_e          state_q, state_d;
  logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
  logic [ISI_W-1:0]    isi_cnt_q, isi_cnt_d, isi_inc;
  logic                first_q, first_d;
  logic [WINDOW_W-1:0] win_q, win_d;
  logic [7:0]          scnt_q, scnt_d, scnt_inc, rate_q, rate_d;
  logic                rate_valid_q, rate_valid_d;
  logic                spike_q, spike_d;
  logic                overflow_q, overflow_d;
  logic                above, spike_now, push, pop, fifo_full, fifo_empty;
  evt_t                push_evt, head_evt;

  assign above    = (v_mem_i >= THRESH);
  assign isi_inc  = (isi_cnt_q == ISI_MAX) ? ISI_MAX : isi_cnt_q + 1'b1;
  assign scnt_inc = (scnt_q == 8'hFF) ? 8'hFF : scnt_q + 8'd1;
  assign pop      = !fifo_empty && evt_ready_i;
  assign push     = spike_now && !clear_i;

  always_comb begin
    push_evt.first = first_q;
    push_evt.isi   = isi_inc;
  end

  always_comb begin
    state_d      = state_q;
    rcnt_d       = rcnt_q;
    isi_cnt_d    = isi_cnt_q;
    first_d      = first_q;
    win_d        = win_q;
    scnt_d       = scnt_q;
    rate_d       = rate_q;
    rate_valid_d = 1'b0;
    spike_now    = 1'b0;

    if (v_valid_i) begin
      if (state_q == ST_ARMED) begin
        if (above) begin
          spike_now = 1'b1;
          rcnt_d    = RCNT_LOAD;
          state_d   = ST_REFRACT;
        end
      end else if (rcnt_q != '0) begin
        rcnt_d = rcnt_q - RCNT_W'(1);
      end else if (!above) begin
        state_d = ST_ARMED;
      end

      isi_cnt_d = spike_now ? '0 : isi_inc;
      if (spike_now) first_d = 1'b0;

      win_d = win_q + WINDOW_W'(1);
      // The wrapping sample's own spike belongs to the window it closes.
      if (win_q == '1) begin
        rate_d       = spike_now ? scnt_inc : scnt_q;
        rate_valid_d = 1'b1;
        scnt_d       = '0;
      end else if (spike_now) begin
        scnt_d = scnt_inc;
      end
    end

    spike_d    = spike_now;
    overflow_d = overflow_q | (spike_now && fifo_full && !pop);

    if (clear_i) begin
      state_d      = ST_ARMED;
      rcnt_d       = '0;
      isi_cnt_d    = '0;
      first_d      = 1'b1;
      win_d        = '0;
      scnt_d       = '0;
      rate_d       = '0;
      rate_valid_d = 1'b0;
      spike_d      = 1'b0;
      overflow_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_ARMED;
      rcnt_q       <= '0;
      isi_cnt_q    <= '0;
      first_q      <= 1'b1;
      win_q        <= '0;
      scnt_q       <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      spike_q      <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rcnt_q       <= rcnt_d;
      isi_cnt_q    <= isi_cnt_d;
      first_q      <= first_d;
      win_q        <= win_d;
      scnt_q       <= scnt_d;
      rate_q       <= rate_d;
      rate_valid_q <= rate_valid_d;
      spike_q      <= spike_d;
      overflow_q   <= overflow_d;
    end
  end

  izh_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (evt_t)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (clear_i),
    .push_i     (push),
    .push_dat_i (push_evt),
    .pop_i      (pop),
    .pop_dat_o  (head_evt),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign spike_o      = spike_q;
  assign evt_valid_o  = !fifo_empty;
  assign evt_isi_o    = head_evt.isi;
  assign evt_first_o  = head_evt.first;
  assign rate_o       = rate_q;
  assign rate_valid_o = rate_valid_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_izh_spike_monitor.sv
// Randomized and directed bench for izh_spike_monitor against a sample-indexed reference model.
module tb_izh_spike_monitor;

  localparam int THRESH  = 19;
  localparam int REFRACT = 2;
  localparam int DEPTH   = 4;
  localparam int WW      = 4;
  localparam int WIN     = 1 << WW;
  localparam int ISI_MAX = 65535;

  logic        clk = 1'b0;
  logic        rst_n, clear, v_valid, evt_ready;
  logic [7:0]  v_mem;
  logic        spike, evt_valid, evt_first, rate_valid, overflow;
  logic [15:0] evt_isi;
  logic [7:0]  rate;

  int n_tests = 0;
  int n_fail  = 0;
  int n_spk   = 0;

  always #5 clk = ~clk;

  izh_spike_monitor #(.WINDOW_W(WW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clear_i      (clear),
    .v_mem_i      (v_mem),
    .v_valid_i    (v_valid),
    .spike_o      (spike),
    .evt_valid_o  (evt_valid),
    .evt_ready_i  (evt_ready),
    .evt_isi_o    (evt_isi),
    .evt_first_o  (evt_first),
    .rate_o       (rate),
    .rate_valid_o (rate_valid),
    .overflow_o   (overflow)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: sample index based, events kept in a queue.
  typedef struct { int isi; bit first; } ev_t;
  ev_t mq[$];
  ev_t m_shown;
  int  m_idx, m_last, m_winspk, e_rate;
  bit  m_armed, m_first_pend, m_ovf, e_spike, e_rv;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_shown      = '{isi: 0, first: 1'b0};
    m_idx        = 0;
    m_last       = 0;
    m_winspk     = 0;
    e_rate       = 0;
    m_armed      = 1'b1;
    m_first_pend = 1'b1;
    m_ovf        = 1'b0;
    e_spike      = 1'b0;
    e_rv         = 1'b0;
  endtask

  task automatic check_all();
    ev_t h;
    h = (mq.size() > 0) ? mq[0] : m_shown;
    chk("spike",      spike,      e_spike);
    chk("evt_valid",  evt_valid,  (mq.size() > 0) ? 1 : 0);
    chk("evt_isi",    evt_isi,    h.isi);
    chk("evt_first",  evt_first,  h.first);
    chk("rate",       rate,       e_rate);
    chk("rate_valid", rate_valid, e_rv);
    chk("overflow",   overflow,   m_ovf);
  endtask

  task automatic step(input int v, input bit vld, input bit rdy, input bit clr);
    bit  pop, spk;
    ev_t ev;
    @(negedge clk);
    v_mem     = v[7:0];
    v_valid   = vld;
    evt_ready = rdy;
    clear     = clr;
    ev  = '{isi: 0, first: 1'b0};
    spk = 1'b0;
    if (clr) begin
      model_reset();
    end else begin
      pop  = (mq.size() > 0) && rdy;
      e_rv = 1'b0;
      if (vld) begin
        m_idx++;
        if (m_armed) begin
          if (v >= THRESH) spk = 1'b1;
        end else if ((m_idx - m_last > REFRACT) && (v < THRESH)) begin
          m_armed = 1'b1;
        end
        if (spk) begin
          ev.isi       = imin(m_idx - m_last, ISI_MAX);
          ev.first     = m_first_pend;
          m_first_pend = 1'b0;
          m_last       = m_idx;
          m_armed      = 1'b0;
        end
        if (m_idx % WIN == 0) begin
          e_rate   = imin(m_winspk + int'(spk), 255);
          e_rv     = 1'b1;
          m_winspk = 0;
        end else begin
          m_winspk += int'(spk);
        end
      end
      if (pop) m_shown = mq.pop_front();
      if (spk) begin
        if (mq.size() < DEPTH) mq.push_back(ev);
        else m_ovf = 1'b1;
      end
      e_spike = spk;
    end
    @(posedge clk);
    #1;
    check_all();
    if (spike) n_spk++;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_spike"},      spike,      0);
    chk({pfx, "_evt_valid"},  evt_valid,  0);
    chk({pfx, "_evt_isi"},    evt_isi,    0);
    chk({pfx, "_evt_first"},  evt_first,  0);
    chk({pfx, "_rate"},       rate,       0);
    chk({pfx, "_rate_valid"}, rate_valid, 0);
    chk({pfx, "_overflow"},   overflow,   0);
  endtask

  // Asserts rst_n between edges and checks outputs fall without a clock.
  task automatic async_reset(input string pfx);
    @(negedge clk);
    #2;
    rst_n     = 1'b0;
    v_valid   = 1'b0;
    clear     = 1'b0;
    evt_ready = 1'b0;
    #1;
    chk_zero(pfx);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic spike_pattern(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      step(25, 1'b1, rdy, 1'b0);
      for (int j = 0; j < 3; j++) step(-65, 1'b1, rdy, 1'b0);
    end
  endtask

  initial begin
    int v, base;
    rst_n = 1'b0; clear = 1'b0; v_valid = 1'b0; evt_ready = 1'b0; v_mem = '0;
    model_reset();
    #12;
    chk_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Single spike, then a second after 9 sub-threshold samples.
    step(-65, 1, 0, 0);
    step(-10, 1, 0, 0);
    step(25, 1, 0, 0);
    chk("t1_spike", spike, 1);
    chk("t1_isi", evt_isi, 3);
    chk("t1_first", evt_first, 1);
    step(-65, 1, 0, 0);
    chk("t1_one_pulse", spike, 0);
    for (int i = 0; i < 8; i++) step(-65, 1, 0, 0);
    step(25, 1, 0, 0);
    chk("t2_head_still_first", evt_isi, 3);
    step(-65, 1, 1, 0);
    chk("t2_isi", evt_isi, 10);
    chk("t2_first", evt_first, 0);
    step(-65, 1, 1, 0);
    chk("t2_empty", evt_valid, 0);
    chk("t2_hold_isi", evt_isi, 10);

    // Refractory hold-off.
    for (int i = 0; i < 4; i++) step(-65, 1, 1, 0);
    n_spk = 0;
    step(25, 1, 1, 0); step(-65, 1, 1, 0); step(25, 1, 1, 0);
    chk("refr_a", n_spk, 1);
    for (int i = 0; i < 4; i++) step(-65, 1, 1, 0);
    n_spk = 0;
    step(25, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(-65, 1, 1, 0);
    step(25, 1, 1, 0);
    chk("refr_b", n_spk, 2);
    for (int i = 0; i < 4; i++) step(-65, 1, 1, 0);
    n_spk = 0;
    for (int i = 0; i < 20; i++) step(25, 1, 1, 0);
    chk("refr_sustained", n_spk, 1);

    // Overflow and drain.
    step(0, 0, 0, 1);
    spike_pattern(6, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("ovf_head_isi", evt_isi, 1);
    for (int i = 0; i < 5; i++) step(-65, 1, 1, 0);
    chk("ovf_drained", evt_valid, 0);
    chk("ovf_sticky", overflow, 1);

    // Full queue with simultaneous pop during a spike.
    step(0, 0, 0, 1);
    spike_pattern(4, 1'b0);
    step(25, 1, 1, 0);
    chk("full_pop_no_drop", overflow, 0);

    // Rate window of 16 samples holding 3 spikes.
    step(0, 0, 0, 1);
    spike_pattern(3, 1'b1);
    for (int i = 0; i < 4; i++) step(-65, 1, 1, 0);
    chk("rate_val", rate, 3);
    chk("rate_pulse", rate_valid, 1);
    step(-65, 1, 1, 0);
    chk("rate_pulse_once", rate_valid, 0);

    // Randomized traffic with occasional clear and idle samples.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: v = int'($urandom_range(0, 60)) - 80;
        1: v = int'($urandom_range(17, 21));
        2: v = int'($urandom_range(19, 127));
        default: v = int'($urandom_range(0, 255)) - 128;
      endcase
      step(v, ($urandom_range(0, 4) != 0), $urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0);
    end

    // ISI saturation.
    step(0, 0, 0, 1);
    for (int i = 0; i < 70000; i++) step(-65, 1, 1, 0);
    step(25, 1, 1, 0);
    chk("sat_isi", evt_isi, 65535);
    chk("sat_first", evt_first, 1);

    // Async reset with two events queued.
    base = 0;
    step(0, 0, 0, 1);
    spike_pattern(2, 1'b0);
    chk("pre_rst_valid", evt_valid, 1);
    async_reset("arst");
    step(-65, 1, 1, base[0]);
    step(25, 1, 1, 0);
    chk("post_rst_first", evt_first, 1);
    chk("post_rst_isi", evt_isi, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
